// File: rtl/usb_rw_pkg.sv
// Shared types and constants for the USB read/write request sequencer.
package usb_rw_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR_ISSUE = 3'd1,
    ADDR_WAIT  = 3'd2,
    DATA_ISSUE = 3'd3,
    DATA_WAIT  = 3'd4,
    FINISH     = 3'd5
  } rw_state_t;

  typedef enum logic {
    RW_WRITE = 1'b0,
    RW_READ  = 1'b1
  } rw_op_t;

  // OUT payload lengths in bytes
  localparam logic [3:0] ADDR_LEN = 4'd2;
  localparam logic [3:0] DATA_LEN = 4'd8;

endpackage

// File: rtl/usb_rw_attempt_ctr.sv
// Attempt counter for one transaction phase, plus an optional per-attempt
// watchdog compiled in with RW_TIMEOUT_EN.
module usb_rw_attempt_ctr #(
  parameter logic [3:0] MAX_ATTEMPTS = 4'd8,
  parameter logic [7:0] TIMEOUT      = 8'd255
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clear,
  input  logic inc,
  input  logic waiting,
  output logic retry_ok,
  output logic timed_out
);

  logic [3:0] attempts;

  // Count issued attempts; clear at request start and at the phase change
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      attempts <= 4'd0;
    end else if (clear) begin
      attempts <= 4'd0;
    end else if (inc) begin
      attempts <= attempts + 4'd1;
    end
  end

  assign retry_ok = (attempts < MAX_ATTEMPTS);

`ifdef RW_TIMEOUT_EN
  logic [7:0] wd;

  // Cycles spent in the current wait; zero in the first wait cycle so the
  // retry lands TIMEOUT+1 cycles after the previous txn_start
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wd <= 8'd0;
    end else if (!waiting) begin
      wd <= 8'd0;
    end else begin
      wd <= wd + 8'd1;
    end
  end

  assign timed_out = waiting && (wd == (TIMEOUT - 8'd1));
`else
  logic unused_wd;

  assign unused_wd = ^{waiting, TIMEOUT};
  assign timed_out = 1'b0;
`endif

endmodule

// File: rtl/usb_rw_controller.sv
// Sequences one 16-bit-addressed 64-bit read or write as an address OUT
// followed by a data OUT (write) or data IN (read), with bounded retries.
// Optional build macro: RW_TIMEOUT_EN adds a per-attempt watchdog.
module usb_rw_controller
  import usb_rw_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'd5,
  parameter logic [3:0] ADDR_ENDP    = 4'd4,
  parameter logic [3:0] DATA_ENDP    = 4'd8,
  parameter logic [3:0] MAX_ATTEMPTS = 4'd8,
  parameter logic [7:0] TIMEOUT      = 8'd255
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        start_write,
  input  logic        start_read,
  input  logic [15:0] addr,
  input  logic [63:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [63:0] data_out,
  output logic        txn_start,
  output logic        txn_is_in,
  output logic [6:0]  txn_dev,
  output logic [3:0]  txn_endp,
  output logic [3:0]  txn_len,
  output logic [63:0] txn_payload,
  input  logic        txn_done,
  input  logic        txn_ok,
  input  logic [63:0] txn_rx_data
);

  rw_state_t   state, state_n;
  rw_op_t      op_r;
  logic [63:0] data_r;
  logic        accept;
  logic        data_load;
  logic        ctr_clear;
  logic        set_ok;
  logic        capture;
  logic        waiting;
  logic        retry_ok;
  logic        timed_out;

  assign waiting   = (state == ADDR_WAIT) || (state == DATA_WAIT);
  assign txn_start = (state == ADDR_ISSUE) || (state == DATA_ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

  usb_rw_attempt_ctr #(
    .MAX_ATTEMPTS (MAX_ATTEMPTS),
    .TIMEOUT      (TIMEOUT)
  ) u_ctr (
    .clk       (clk),
    .rst_L     (rst_L),
    .clear     (ctr_clear),
    .inc       (txn_start),
    .waiting   (waiting),
    .retry_ok  (retry_ok),
    .timed_out (timed_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and per-cycle control strobes; txn_done beats a timeout
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    data_load = 1'b0;
    ctr_clear = 1'b0;
    set_ok    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start_write || start_read) begin
          accept    = 1'b1;
          ctr_clear = 1'b1;
          state_n   = ADDR_ISSUE;
        end
      end
      ADDR_ISSUE: state_n = ADDR_WAIT;
      ADDR_WAIT: begin
        if (txn_done && txn_ok) begin
          data_load = 1'b1;
          ctr_clear = 1'b1;
          state_n   = DATA_ISSUE;
        end else if (txn_done || timed_out) begin
          state_n = retry_ok ? ADDR_ISSUE : FINISH;
        end
      end
      DATA_ISSUE: state_n = DATA_WAIT;
      DATA_WAIT: begin
        if (txn_done && txn_ok) begin
          set_ok  = 1'b1;
          capture = (op_r == RW_READ);
          state_n = FINISH;
        end else if (txn_done || timed_out) begin
          state_n = retry_ok ? DATA_ISSUE : FINISH;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Write data holding register; only meaningful once a request is accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      data_r <= data_in;
    end
  end

  // Request opcode, result and transaction fields; fields are loaded ahead
  // of each phase and held unchanged across its retries
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      op_r        <= RW_WRITE;
      success     <= 1'b0;
      data_out    <= 64'd0;
      txn_is_in   <= 1'b0;
      txn_dev     <= 7'd0;
      txn_endp    <= 4'd0;
      txn_len     <= 4'd0;
      txn_payload <= 64'd0;
    end else begin
      if (accept) begin
        op_r        <= start_write ? RW_WRITE : RW_READ;
        success     <= 1'b0;
        txn_is_in   <= 1'b0;
        txn_dev     <= DEV_ADDR;
        txn_endp    <= ADDR_ENDP;
        txn_len     <= ADDR_LEN;
        txn_payload <= {48'd0, addr};
      end
      if (data_load) begin
        if (op_r == RW_WRITE) begin
          txn_is_in   <= 1'b0;
          txn_endp    <= ADDR_ENDP;
          txn_len     <= DATA_LEN;
          txn_payload <= data_r;
        end else begin
          txn_is_in   <= 1'b1;
          txn_endp    <= DATA_ENDP;
          txn_len     <= 4'd0;
          txn_payload <= 64'd0;
        end
      end
      if (set_ok) begin
        success <= 1'b1;
      end
      if (capture) begin
        data_out <= txn_rx_data;
      end
    end
  end

endmodule

// File: tb/tb_usb_rw_controller.sv
// Scoreboard bench for usb_rw_controller: expected transactions and results
// are queued when a request is driven and checked as the DUT produces them.
module tb_usb_rw_controller;

  localparam int MAXA = 8;
  localparam int TMO  = 255;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        start_write = 1'b0;
  logic        start_read = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [63:0] data_in = 64'd0;
  logic        busy, done, success;
  logic [63:0] data_out;
  logic        txn_start, txn_is_in;
  logic [6:0]  txn_dev;
  logic [3:0]  txn_endp, txn_len;
  logic [63:0] txn_payload;
  logic        txn_done = 1'b0;
  logic        txn_ok = 1'b0;
  logic [63:0] txn_rx_data = 64'd0;

  usb_rw_controller dut (
    .clk         (clk),
    .rst_L       (rst_L),
    .start_write (start_write),
    .start_read  (start_read),
    .addr        (addr),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .success     (success),
    .data_out    (data_out),
    .txn_start   (txn_start),
    .txn_is_in   (txn_is_in),
    .txn_dev     (txn_dev),
    .txn_endp    (txn_endp),
    .txn_len     (txn_len),
    .txn_payload (txn_payload),
    .txn_done    (txn_done),
    .txn_ok      (txn_ok),
    .txn_rx_data (txn_rx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_in;
    logic [6:0]  dev;
    logic [3:0]  endp;
    logic [3:0]  len;
    logic [63:0] payload;
  } txn_t;

  typedef struct {
    logic        succ;
    logic [63:0] dout;
  } res_t;

  txn_t        q_txn[$];
  res_t        q_res[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] dout_model = 64'd0;

  // engine behaviour knobs
  int          afail = 0;
  int          dfail = 0;
  int          eng_delay = 2;
  bit          eng_silent = 1'b0;
  logic [63:0] eng_rx = 64'd0;
  int          addr_att = 0;
  int          data_att = 0;
  int          cyc = 0;
  int          last_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction engine model: checks each txn_start against the scoreboard
  task automatic serve();
    txn_t e;
    bit   is_addr;
    bit   ok;
    bit   aborted;
    is_addr = !txn_is_in && (txn_len == 4'd2);
    if (is_addr) addr_att++;
    else data_att++;
    if (eng_silent && ((is_addr ? addr_att : data_att) > 1))
      check("wd_period", 64'(cyc - last_start), 64'(TMO + 1));
    last_start = cyc;
    if (q_txn.size() == 0) begin
      check("txn_unexpected", 64'd1, 64'd0);
    end else begin
      e = q_txn.pop_front();
      check("txn_is_in", 64'(txn_is_in), 64'(e.is_in));
      check("txn_dev", 64'(txn_dev), 64'(e.dev));
      check("txn_endp", 64'(txn_endp), 64'(e.endp));
      check("txn_len", 64'(txn_len), 64'(e.len));
      if (!e.is_in) check("txn_payload", txn_payload, e.payload);
    end
    ok = is_addr ? (addr_att > afail) : (data_att > dfail);
    if (eng_silent) begin
      @(negedge clk);
      return;
    end
    aborted = 1'b0;
    for (int i = 0; i < eng_delay; i++) begin
      @(negedge clk);
      if (!rst_L) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) return;
    txn_done    = 1'b1;
    txn_ok      = ok;
    txn_rx_data = ok ? eng_rx : ~eng_rx;
    @(negedge clk);
    txn_done = 1'b0;
    txn_ok   = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (rst_L && txn_start) serve();
    end
  end

  // Result monitor: pops the expected outcome on every done pulse
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_L && done) begin
        if (q_res.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          r = q_res.pop_front();
          check("success", 64'(success), 64'(r.succ));
          check("data_out", data_out, r.dout);
        end
        check("busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_fall", 64'(busy), 64'd0);
      end
    end
  end

  task automatic run_req(input bit wr, input bit both, input logic [15:0] a,
                         input logic [63:0] d, input int af, input int df,
                         input logic [63:0] rx);
    int na;
    int nd;
    bit succ;
    afail = af;
    dfail = df;
    eng_rx = rx;
    addr_att = 0;
    data_att = 0;
    na = (af >= MAXA) ? MAXA : af + 1;
    nd = 0;
    succ = 1'b0;
    if (af < MAXA) begin
      nd = (df >= MAXA) ? MAXA : df + 1;
      succ = (df < MAXA);
    end
    repeat (na) q_txn.push_back('{1'b0, 7'd5, 4'd4, 4'd2, {48'd0, a}});
    repeat (nd) begin
      if (wr) q_txn.push_back('{1'b0, 7'd5, 4'd4, 4'd8, d});
      else q_txn.push_back('{1'b1, 7'd5, 4'd8, 4'd0, 64'd0});
    end
    if (!wr && succ) dout_model = rx;
    q_res.push_back('{succ, dout_model});
    @(negedge clk);
    addr = a;
    data_in = d;
    start_write = wr;
    start_read = !wr || both;
    @(negedge clk);
    start_write = 1'b0;
    start_read = 1'b0;
    check("start_latency", 64'(txn_start), 64'd1);
    check("busy_rise", 64'(busy), 64'd1);
    if (both) begin
      repeat (3) @(negedge clk);
      addr = ~a;
      start_read = 1'b1;
      @(negedge clk);
      start_read = 1'b0;
    end
    for (int i = 0; i < 5000 && q_res.size() != 0; i++) @(negedge clk);
    check("request_timeout", 64'(q_res.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("addr_attempts", 64'(addr_att), 64'(na));
    check("data_attempts", 64'(data_att), 64'(nd));
    check("txn_leftover", 64'(q_txn.size()), 64'd0);
    q_res.delete();
    q_txn.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_success", 64'({done, success, txn_start}), 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_txn_fields", 64'({txn_is_in, txn_dev, txn_endp, txn_len}), 64'd0);
    check("rst_txn_payload", txn_payload, 64'd0);
    #2 rst_L = 1'b1;

    run_req(1'b1, 1'b0, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'd0);
    run_req(1'b0, 1'b0, 16'h1234, 64'd0, 0, 0, 64'hDEAD_BEEF_0123_4567);
    run_req(1'b1, 1'b0, 16'hA5A5, 64'h0123_4567_89AB_CDEF, 3, 0, 64'd0);
    run_req(1'b0, 1'b0, 16'h0042, 64'd0, 0, 99, 64'hCAFE_F00D_1111_2222);
    run_req(1'b1, 1'b1, 16'h5A5A, 64'h1122_3344_5566_7788, 0, 0, 64'd0);

    // abort a read with reset while its data IN is outstanding
    afail = 0;
    dfail = 0;
    eng_delay = 30;
    addr_att = 0;
    data_att = 0;
    q_txn.push_back('{1'b0, 7'd5, 4'd4, 4'd2, 64'h0BAD});
    q_txn.push_back('{1'b1, 7'd5, 4'd8, 4'd0, 64'd0});
    @(negedge clk);
    addr = 16'h0BAD;
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    for (int i = 0; i < 200 && data_att == 0; i++) @(negedge clk);
    check("abort_reached_data", 64'(data_att), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_L = 1'b0;
    #1;
    check("abort_busy_done", 64'({busy, done, success, txn_start}), 64'd0);
    check("abort_data_out", data_out, 64'd0);
    check("abort_txn_fields", 64'({txn_is_in, txn_dev, txn_endp, txn_len}), 64'd0);
    check("abort_txn_payload", txn_payload, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_L = 1'b1;
    dout_model = 64'd0;
    q_txn.delete();
    eng_delay = 2;
    repeat (2) @(negedge clk);
    run_req(1'b0, 1'b0, 16'h7777, 64'd0, 0, 1, 64'h0F0F_F0F0_AAAA_5555);

`ifdef RW_TIMEOUT_EN
    eng_silent = 1'b1;
    run_req(1'b1, 1'b0, 16'h0001, 64'h0000_0000_0000_0099, MAXA, 0, 64'd0);
    eng_silent = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
